cpu_run_ctrl: RTL
=================

// Module: cpu_run_ctrl
// PURPOSE
//  Execution controller sitting directly upstream of the Hack Computer core.
//  Debounces the board push-buttons and produces the CPU clock-enable and reset.
//  Supports three ways to advance the CPU:
//   - free-run at a switch-selected rate,
//   - single-step,
//   - pause on a PC breakpoint.
//  Also counts executed instructions for the 7-segment display path.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  stable-level cycles before a button edge is accepted (10 ms @ 50 MHz)
//  PRESCALE_W       24      width of run-rate divider; max period 2^PRESCALE_W cycles
//  RESET_CYCLES     4       length of the CPU reset pulse, in clk cycles
// PORTS
//  clk         in   1   system clock (50 MHz)
//  reset_n     in   1   asynchronous active-low reset
//  btn         in   3   raw DE0 buttons, active-low: [0]=step [1]=run/pause toggle [2]=cpu reset
//  rate        in   5   run-rate select (top ties to sw[4:0]); period = 2^min(rate,PRESCALE_W) cycles
//  bp_en       in   1   breakpoint enable
//  bp_addr     in   15  breakpoint PC
//  pc          in   15  current CPU PC (debug_pc)
//  cpu_en      out  1   one-cycle clock-enable pulse to the Computer
//  cpu_reset   out  1   active-high reset to the Computer
//  mode        out  2   current state encoding (drives led[1:0])
//  inst_count  out  16  executed-instruction counter
// BEHAVIOUR
//  Reset (reset_n=0, async): state=RESET_HOLD, cpu_reset=1, cpu_en=1, inst_count=0,
//   divider=0, all debouncers idle/released, ret_mode=RUN, skip_bp=0.
//  Debounce: each button is synchronised through 2 flops, then inverted.
//   A level change is accepted only after DEBOUNCE_CYCLES consecutive stable cycles.
//   An accepted press (released->pressed) yields exactly one 1-cycle pulse.
//   Releases produce no pulse.
//  States (mode encoding):
//   RESET_HOLD=2'b11: cpu_reset=1, cpu_en=1 for RESET_CYCLES cycles, then -> ret_mode.
//   RUN=2'b01:        divider increments every cycle; cpu_en=1 when divider==2^r-1,
//                     then divider clears.
//                     r=min(rate,PRESCALE_W); r=0 -> cpu_en every cycle.
//   PAUSE=2'b10:      cpu_en=0 except a single-cycle cpu_en on each step pulse.
//  Transitions and pulse handling:
//   - RUN: toggle pulse -> PAUSE; divider clears.
//   - PAUSE: toggle pulse -> RUN; divider clears; skip_bp=1.
//   - Any state: cpu-reset pulse -> RESET_HOLD.
//     ret_mode = current mode (RESET_HOLD keeps the old ret_mode); inst_count clears.
//   - Step pulses in RUN or RESET_HOLD are ignored.
//   - Priority of simultaneous pulses: reset > toggle > step.
//  Breakpoint (RUN only):
//   - When cpu_en would fire with bp_en=1, pc==bp_addr and skip_bp=0:
//     suppress the pulse (cpu_en=0) and go to PAUSE.
//   - skip_bp clears on the first cpu_en issued in RUN, so resuming executes past the bp.
//   - Single-step in PAUSE ignores the breakpoint.
//  inst_count: +1 on every cpu_en while cpu_reset=0; wraps 16'hFFFF -> 0.
//  Outputs are registered: cpu_en, cpu_reset and mode change 1 cycle after the decision.
//  rate changes take effect at the next divider compare.
//   If the divider already exceeds the new terminal value, it wraps through 2^PRESCALE_W
//   (accepted; no special case).
//  reset_n asserted mid-operation: immediate return to the reset values above, any state.
// STRUCTURE
//  hw_pkg: typedef enum logic[1:0] run_mode_t {RUN, PAUSE, RESET_HOLD};
//   also BTN_STEP/BTN_TOGGLE/BTN_RESET index constants.
//  Sub-module btn_debounce (sync + counter + press pulse, parameter DEBOUNCE_CYCLES),
//   instantiated 3x.
//  Top-level wiring: cpu_en gates the Computer's state update; inst_count or outM selects
//   the hex display source.
// TESTING (DEBOUNCE_CYCLES=4, RESET_CYCLES=4, PRESCALE_W=8)
//  1 Release reset_n.
//    -> cpu_reset=1 for 4 cycles, then mode=01, and cpu_en every cycle with rate=0.
//  2 rate=3 in RUN.
//    -> cpu_en exactly every 8 cycles; inst_count=5 after 40 cycles of RUN.
//  3 Press btn[1] with 3-cycle bounces, then stable.
//    -> exactly one toggle, mode=10, cpu_en stays 0.
//    Then 3 clean btn[0] presses -> exactly 3 cpu_en pulses.
//  4 RUN, bp_en=1, bp_addr=15'h0010; pc reaches 0x0010.
//    -> no cpu_en at that compare, mode=10.
//    Toggle -> RUN; the first pulse fires at pc=0x0010, then normal running.
//  5 PAUSE with inst_count=7; press btn[2].
//    -> inst_count=0, cpu_reset=1 for 4 cycles, then back to PAUSE.
//    Toggle and reset pulses in the same cycle -> reset wins.
//  6 Assert reset_n mid RESET_HOLD and mid divider count.
//    -> outputs return to reset values immediately.
//    Run inst_count past 16'hFFFF -> wraps to 0.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU execution controller.
//  run_mode_t   : controller state, encoded exactly as it appears on the mode/LED output
//  BTN_*        : bit positions of the step, run/pause and cpu-reset buttons in btn[2:0]
//  eff_rate     : clamps the 5-bit rate select to the divider width
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'b01,
        PAUSE      = 2'b10,
        RESET_HOLD = 2'b11
    } run_mode_t;

    localparam int BTN_STEP   = 0;
    localparam int BTN_TOGGLE = 1;
    localparam int BTN_RESET  = 2;

    // Effective divider exponent: min(rate, width).
    function automatic int eff_rate(input logic [4:0] rate, input int width);
        int r;
        r = int'(rate);
        if (r > width) begin
            return width;
        end else begin
            return r;
        end
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// Push-button debouncer with press detection.
//  clk      : system clock
//  reset_n  : asynchronous active-low reset (button treated as released)
//  btn_n    : raw active-low button
//  press    : registered one-cycle pulse on each accepted released->pressed change
// The raw level is synchronised through two flops and inverted; a new level is
// accepted only after DEBOUNCE_CYCLES consecutive cycles that differ from the
// currently accepted level. Releases are accepted silently.
module cpu_run_ctrl_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_r;
    logic          stable_r;
    logic [CW-1:0] cnt_r;
    logic          press_r;
    logic          level_s;

    // Synchronised, active-high pressed level.
    always_comb begin
        level_s = ~sync_r[1];
    end

    // Synchroniser, stability counter and press pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r   <= 2'b11;
            stable_r <= 1'b0;
            cnt_r    <= '0;
            press_r  <= 1'b0;
        end else begin
            sync_r  <= {sync_r[0], btn_n};
            press_r <= 1'b0;
            if (level_s == stable_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                // Level held long enough: accept it; only a press emits a pulse.
                stable_r <= level_s;
                cnt_r    <= '0;
                press_r  <= level_s;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Execution controller for the Hack Computer core.
//  clk, reset_n : system clock, asynchronous active-low reset
//  btn[2:0]     : raw active-low buttons: [0] step, [1] run/pause toggle, [2] cpu reset
//  rate[4:0]    : free-run period select, period = 2^min(rate,PRESCALE_W) cycles
//  bp_en        : breakpoint enable
//  bp_addr[14:0]: breakpoint PC
//  pc[14:0]     : current CPU program counter
//  cpu_en       : registered one-cycle clock-enable pulse to the CPU
//  cpu_reset    : registered active-high CPU reset
//  mode[1:0]    : current run_mode_t encoding
//  inst_count   : instructions executed since the last CPU reset (wraps)
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PRESCALE_W      = 24,
    parameter int RESET_CYCLES    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  btn,
    input  logic [4:0]  rate,
    input  logic        bp_en,
    input  logic [14:0] bp_addr,
    input  logic [14:0] pc,
    output logic        cpu_en,
    output logic        cpu_reset,
    output logic [1:0]  mode,
    output logic [15:0] inst_count
);

    localparam int HW = $clog2(RESET_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);

    logic [2:0]            press_s;
    run_mode_t             state_r, state_next_s;
    run_mode_t             ret_mode_r, ret_mode_next_s;
    logic [HW-1:0]         hold_cnt_r, hold_cnt_next_s;
    logic [PRESCALE_W-1:0] div_r, div_next_s, term_s;
    logic                  skip_bp_r, skip_bp_next_s;
    logic                  cpu_en_r, cpu_en_next_s;
    logic                  cpu_reset_r, cpu_reset_next_s;
    logic                  inst_clr_s;
    logic                  bp_hit_s;
    logic [15:0]           inst_count_r;

    cpu_run_ctrl_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_n   (btn[BTN_STEP]),
        .press   (press_s[BTN_STEP])
    );

    cpu_run_ctrl_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_toggle (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_n   (btn[BTN_TOGGLE]),
        .press   (press_s[BTN_TOGGLE])
    );

    cpu_run_ctrl_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_reset (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_n   (btn[BTN_RESET]),
        .press   (press_s[BTN_RESET])
    );

    // Divider terminal value 2^r-1 and breakpoint match.
    always_comb begin
        int eff;
        eff    = eff_rate(rate, PRESCALE_W);
        term_s = '0;
        for (int i = 0; i < PRESCALE_W; i++) begin
            term_s[i] = (i < eff);
        end
        bp_hit_s = bp_en && (pc == bp_addr) && !skip_bp_r;
    end

    // Next-state and next-output decision; pulse priority is reset > toggle > step.
    always_comb begin
        state_next_s     = state_r;
        ret_mode_next_s  = ret_mode_r;
        hold_cnt_next_s  = hold_cnt_r;
        div_next_s       = div_r;
        skip_bp_next_s   = skip_bp_r;
        cpu_en_next_s    = 1'b0;
        cpu_reset_next_s = 1'b0;
        inst_clr_s       = 1'b0;

        if (press_s[BTN_RESET]) begin
            state_next_s     = RESET_HOLD;
            hold_cnt_next_s  = '0;
            div_next_s       = '0;
            cpu_en_next_s    = 1'b1;
            cpu_reset_next_s = 1'b1;
            inst_clr_s       = 1'b1;
            // A reset during the hold must not lose the mode to return to.
            if (state_r != RESET_HOLD) begin
                ret_mode_next_s = state_r;
            end else begin
                ret_mode_next_s = ret_mode_r;
            end
        end else begin
            case (state_r)
                RESET_HOLD: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_next_s    = ret_mode_r;
                        hold_cnt_next_s = '0;
                    end else begin
                        cpu_en_next_s    = 1'b1;
                        cpu_reset_next_s = 1'b1;
                        hold_cnt_next_s  = hold_cnt_r + HW'(1);
                    end
                end
                RUN: begin
                    if (press_s[BTN_TOGGLE]) begin
                        state_next_s = PAUSE;
                        div_next_s   = '0;
                    end else if (div_r == term_s) begin
                        div_next_s = '0;
                        if (bp_hit_s) begin
                            state_next_s = PAUSE;
                        end else begin
                            cpu_en_next_s  = 1'b1;
                            skip_bp_next_s = 1'b0;
                        end
                    end else begin
                        div_next_s = div_r + PRESCALE_W'(1);
                    end
                end
                PAUSE: begin
                    if (press_s[BTN_TOGGLE]) begin
                        // Resume past a breakpoint the CPU is currently parked on.
                        state_next_s   = RUN;
                        div_next_s     = '0;
                        skip_bp_next_s = 1'b1;
                    end else if (press_s[BTN_STEP]) begin
                        cpu_en_next_s = 1'b1;
                    end else begin
                        cpu_en_next_s = 1'b0;
                    end
                end
                default: begin
                    state_next_s     = RESET_HOLD;
                    hold_cnt_next_s  = '0;
                    cpu_en_next_s    = 1'b1;
                    cpu_reset_next_s = 1'b1;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= RESET_HOLD;
            ret_mode_r  <= RUN;
            hold_cnt_r  <= '0;
            div_r       <= '0;
            skip_bp_r   <= 1'b0;
            cpu_en_r    <= 1'b1;
            cpu_reset_r <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            ret_mode_r  <= ret_mode_next_s;
            hold_cnt_r  <= hold_cnt_next_s;
            div_r       <= div_next_s;
            skip_bp_r   <= skip_bp_next_s;
            cpu_en_r    <= cpu_en_next_s;
            cpu_reset_r <= cpu_reset_next_s;
        end
    end

    // Instruction counter: counts enables that reach an un-reset CPU.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inst_count_r <= 16'h0000;
        end else if (inst_clr_s) begin
            inst_count_r <= 16'h0000;
        end else if (cpu_en_r && !cpu_reset_r) begin
            inst_count_r <= inst_count_r + 16'd1;
        end else begin
            inst_count_r <= inst_count_r;
        end
    end

    assign cpu_en     = cpu_en_r;
    assign cpu_reset  = cpu_reset_r;
    assign mode       = state_r;
    assign inst_count = inst_count_r;

endmodule
